// File: rtl/div_ctrl.sv
// Sequencing controller between EX and the iterative divider: launch, stall, HI/LO commit, flush drain.
// Optional watchdog fault detection is compiled in with DIV_WATCHDOG_EN.
module div_ctrl #(
   parameter int WATCHDOG_CYCLES = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_sign,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        flush,
   output logic        stall_req,
   output logic        hilo_we,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata,
   output logic        div_valid,
   output logic        div_sign,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   input  logic        div_busy,
   input  logic [63:0] div_result,
   output logic        div_err
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DONE   = 3'd3,
      ST_DRAIN  = 3'd4
   } state_t;

   state_t state_r;
   logic   wd_fire_s;

`ifdef DIV_WATCHDOG_EN
   localparam int CNT_W = ($clog2(WATCHDOG_CYCLES + 1) > 7) ? $clog2(WATCHDOG_CYCLES + 1) : 7;
   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(WATCHDOG_CYCLES - 1);

   logic [CNT_W-1:0] wd_cnt_r;

   // Fires on the last allowed WAIT/DRAIN cycle while the divider is still busy
   always_comb begin
      wd_fire_s = 1'b0;
      if (div_busy && (wd_cnt_r >= WD_LIMIT)) begin
         if (state_r == ST_DRAIN) begin
            wd_fire_s = 1'b1;
         end else if (state_r == ST_WAIT) begin
            wd_fire_s = !flush;
         end else begin
            wd_fire_s = 1'b0;
         end
      end else begin
         wd_fire_s = 1'b0;
      end
   end

   // Watchdog cycle counter and sticky fault flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_r <= {CNT_W{1'b0}};
         div_err  <= 1'b0;
      end else begin
         if (state_r == ST_LAUNCH) begin
            wd_cnt_r <= {CNT_W{1'b0}};
         end else if ((state_r == ST_WAIT) || (state_r == ST_DRAIN)) begin
            wd_cnt_r <= wd_cnt_r + CNT_W'(1);
         end else begin
            wd_cnt_r <= wd_cnt_r;
         end
         if (wd_fire_s) begin
            div_err <= 1'b1;
         end else begin
            div_err <= div_err;
         end
      end
   end
`else
   assign wd_fire_s = 1'b0;
   assign div_err   = 1'b0;
   // The watchdog limit has no meaning without the watchdog itself
   if (WATCHDOG_CYCLES < 1) begin : g_wd_limit_unused
   end
`endif

   // Main sequencer: operand latching, launch pulse, result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         div_valid <= 1'b0;
         div_sign  <= 1'b0;
         div_a     <= 32'd0;
         div_b     <= 32'd0;
         hi_wdata  <= 32'd0;
         lo_wdata  <= 32'd0;
      end else begin
         div_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req_valid && !flush) begin
                  if (req_b != 32'd0) begin
                     div_sign  <= req_sign;
                     div_a     <= req_a;
                     div_b     <= req_b;
                     div_valid <= 1'b1;
                     state_r   <= ST_LAUNCH;
                  end else begin
                     // Zero divisor never terminates in the divider; answer locally
                     hi_wdata <= req_a;
                     lo_wdata <= 32'hFFFF_FFFF;
                     state_r  <= ST_DONE;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LAUNCH: begin
               state_r <= flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
               if (flush) begin
                  state_r <= ST_DRAIN;
               end else if (!div_busy) begin
                  {hi_wdata, lo_wdata} <= div_result;
                  state_r              <= ST_DONE;
               end else if (wd_fire_s) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_WAIT;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            ST_DRAIN: begin
               if (!div_busy || wd_fire_s) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_DRAIN;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Pipeline hold and HI/LO write strobe decoded from the current state
   always_comb begin
      stall_req = 1'b0;
      hilo_we   = 1'b0;
      case (state_r)
         ST_IDLE:   stall_req = req_valid && !flush;
         ST_LAUNCH: stall_req = 1'b1;
         ST_WAIT:   stall_req = 1'b1;
         ST_DONE:   hilo_we   = !flush;
         ST_DRAIN:  stall_req = req_valid;
         default: begin
            stall_req = 1'b0;
            hilo_we   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl with a behavioural divider stub of programmable latency.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_sign = 1'b0;
   logic [31:0] req_a = 32'd0;
   logic [31:0] req_b = 32'd0;
   logic        flush = 1'b0;
   logic        stall_req, hilo_we, div_valid, div_sign, div_busy, div_err;
   logic [31:0] hi_wdata, lo_wdata, div_a, div_b;
   logic [63:0] div_result;

   int   checks = 0;
   int   failures = 0;
   int   stub_lat = 3;
   logic stub_stuck = 1'b0;
   logic stub_busy_r;
   int   stub_cnt;
   logic [31:0] stub_q, stub_r;

   always #5 clk = ~clk;

   div_ctrl #(.WATCHDOG_CYCLES(10)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_sign(req_sign),
      .req_a(req_a), .req_b(req_b), .flush(flush), .stall_req(stall_req),
      .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
      .div_valid(div_valid), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
      .div_busy(div_busy), .div_result(div_result), .div_err(div_err)
   );

   // Divider stub: busy rises the cycle after div_valid, falls after stub_lat+1 busy cycles
   always @(posedge clk) begin
      if (rst) begin
         stub_busy_r <= 1'b0;
         stub_cnt    <= 0;
      end else if (div_valid) begin
         stub_busy_r <= 1'b1;
         stub_cnt    <= stub_lat;
      end else if (stub_busy_r && !stub_stuck) begin
         if (stub_cnt == 0) stub_busy_r <= 1'b0;
         else stub_cnt <= stub_cnt - 1;
      end
   end
   assign div_busy = stub_busy_r;

   // Stub result with sign fix-up taken combinationally from div_sign
   always_comb begin
      stub_q = 32'd0;
      stub_r = 32'd0;
      if (div_b != 32'd0) begin
         if (div_sign) begin
            stub_q = $signed(div_a) / $signed(div_b);
            stub_r = $signed(div_a) % $signed(div_b);
         end else begin
            stub_q = div_a / div_b;
            stub_r = div_a % div_b;
         end
      end
   end
   assign div_result = {stub_r, stub_q};

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Runs one request to completion and reports what was observed
   task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int nv, output int vo, output int nw, output int wo,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic sok, output logic saw, output logic sgn);
      nv = 0; vo = -1; nw = 0; wo = -1; hi = 32'd0; lo = 32'd0;
      sok = 1'b1; saw = 1'b1; sgn = 1'b1;
      cyc();
      req_valid = 1'b1; req_sign = s; req_a = a; req_b = b;
      #1;
      if (stall_req !== 1'b1) sok = 1'b0;
      for (int k = 1; k <= 60 && nw == 0; k++) begin
         cyc();
         if (div_valid === 1'b1) begin
            nv++;
            if (vo < 0) vo = k;
         end
         if (b != 32'd0 && div_sign !== s) sgn = 1'b0;
         if (hilo_we === 1'b1) begin
            nw++; wo = k; hi = hi_wdata; lo = lo_wdata; saw = stall_req;
            req_valid = 1'b0;
         end else if (stall_req !== 1'b1) begin
            sok = 1'b0;
         end
      end
      req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         if (div_valid === 1'b1) nv++;
         if (hilo_we === 1'b1) nw++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
      cyc(); cyc();
      checks++;
      if ({stall_req, hilo_we, div_valid, div_sign, div_err} !== 5'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b expected=00000", {stall_req, hilo_we, div_valid, div_sign, div_err});
      end
      checks++;
      if ({div_a, div_b} !== 64'd0) begin
         failures++; $display("FAIL reset_operands got=%h expected=0", {div_a, div_b});
      end
      checks++;
      if ({hi_wdata, lo_wdata} !== 64'd0) begin
         failures++; $display("FAIL reset_hilo got=%h expected=0", {hi_wdata, lo_wdata});
      end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_divu();
      int nv, vo, nw, wo; logic [31:0] hi, lo; logic sok, saw, sgn;
      stub_lat = 3;
      do_op(1'b0, 32'd7, 32'd2, nv, vo, nw, wo, hi, lo, sok, saw, sgn);
      checks++;
      if (nv !== 1 || vo !== 1) begin
         failures++; $display("FAIL divu_launch got count=%0d at=%0d expected count=1 at=1", nv, vo);
      end
      checks++;
      if (nw !== 1 || wo !== 7) begin
         failures++; $display("FAIL divu_write got count=%0d at=%0d expected count=1 at=7", nw, wo);
      end
      checks++;
      if (lo !== 32'd3 || hi !== 32'd1) begin
         failures++; $display("FAIL divu_result got lo=%h hi=%h expected lo=3 hi=1", lo, hi);
      end
      checks++;
      if (sok !== 1'b1 || saw !== 1'b0) begin
         failures++; $display("FAIL divu_stall got held=%b at_write=%b expected held=1 at_write=0", sok, saw);
      end
   endtask

   task automatic test_div_signed();
      int nv, vo, nw, wo; logic [31:0] hi, lo; logic sok, saw, sgn;
      stub_lat = 3;
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, nv, vo, nw, wo, hi, lo, sok, saw, sgn);
      checks++;
      if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
         failures++; $display("FAIL div_signed_result got lo=%h hi=%h expected lo=fffffffd hi=ffffffff", lo, hi);
      end
      checks++;
      if (sgn !== 1'b1 || nw !== 1 || wo !== 7) begin
         failures++; $display("FAIL div_signed_seq got sign_stable=%b writes=%0d at=%0d expected 1 1 7", sgn, nw, wo);
      end
   endtask

   task automatic test_div_zero();
      int nv, vo, nw, wo; logic [31:0] hi, lo; logic sok, saw, sgn;
      do_op(1'b0, 32'h1234, 32'd0, nv, vo, nw, wo, hi, lo, sok, saw, sgn);
      checks++;
      if (nv !== 0) begin
         failures++; $display("FAIL divzero_no_launch got=%0d expected=0", nv);
      end
      checks++;
      if (nw !== 1 || wo !== 1 || sok !== 1'b1 || saw !== 1'b0) begin
         failures++; $display("FAIL divzero_timing got writes=%0d at=%0d held=%b stall_at_write=%b expected 1 1 1 0", nw, wo, sok, saw);
      end
      checks++;
      if (hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin
         failures++; $display("FAIL divzero_result got hi=%h lo=%h expected hi=1234 lo=ffffffff", hi, lo);
      end
   endtask

   task automatic test_flush_drain();
      int nv, vo, nw, wo; logic [31:0] hi, lo; logic dok;
      nv = 0; vo = -1; nw = 0; wo = -1; hi = 32'd0; lo = 32'd0; dok = 1'b1;
      stub_lat = 7;
      cyc();
      req_valid = 1'b1; req_sign = 1'b0; req_a = 32'hFFFF_FFFF; req_b = 32'd1;
      for (int k = 1; k <= 60 && nw == 0; k++) begin
         cyc();
         if (k == 7) flush = 1'b1;
         if (k == 8) begin flush = 1'b0; req_valid = 1'b0; stub_lat = 3; end
         if (k == 9) begin req_valid = 1'b1; req_a = 32'd100; req_b = 32'd7; end
         #1;
         if (div_valid === 1'b1) begin nv++; vo = k; end
         if ((k == 9 || k == 10) && stall_req !== 1'b1) dok = 1'b0;
         if (hilo_we === 1'b1) begin
            nw++; wo = k; hi = hi_wdata; lo = lo_wdata; req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         if (hilo_we === 1'b1) nw++;
      end
      checks++;
      if (dok !== 1'b1) begin
         failures++; $display("FAIL drain_stall got=0 expected=1");
      end
      checks++;
      if (nv !== 2 || vo !== 12) begin
         failures++; $display("FAIL drain_relaunch got count=%0d last_at=%0d expected count=2 last_at=12", nv, vo);
      end
      checks++;
      if (nw !== 1 || wo !== 18) begin
         failures++; $display("FAIL drain_write got count=%0d at=%0d expected count=1 at=18", nw, wo);
      end
      checks++;
      if (lo !== 32'd14 || hi !== 32'd2) begin
         failures++; $display("FAIL drain_result got lo=%h hi=%h expected lo=e hi=2", lo, hi);
      end
   endtask

   task automatic test_flush_same_cycle();
      int nv, nw; logic wst;
      nv = 0; nw = 0; wst = 1'b1;
      stub_lat = 2;
      cyc();
      req_valid = 1'b1; req_sign = 1'b0; req_a = 32'd50; req_b = 32'd5;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         if (k == 5) flush = 1'b1;
         if (k == 6) begin flush = 1'b0; req_valid = 1'b0; end
         #1;
         if (k == 5 && stall_req !== 1'b1) wst = 1'b0;
         if (div_valid === 1'b1) nv++;
         if (hilo_we === 1'b1) nw++;
      end
      checks++;
      if (nw !== 0 || nv !== 1 || wst !== 1'b1) begin
         failures++; $display("FAIL flush_wins got writes=%0d launches=%0d stall=%b expected 0 1 1", nw, nv, wst);
      end
      checks++;
      if (hi_wdata !== 32'd2 || lo_wdata !== 32'd14 || stall_req !== 1'b0) begin
         failures++; $display("FAIL flush_hold got hi=%h lo=%h stall=%b expected hi=2 lo=e stall=0", hi_wdata, lo_wdata, stall_req);
      end
   endtask

   task automatic test_flush_at_done();
      int nw; logic dwe, dst;
      nw = 0;
      cyc();
      req_valid = 1'b1; req_sign = 1'b0; req_a = 32'd5; req_b = 32'd0;
      cyc();
      flush = 1'b1;
      #1;
      dwe = hilo_we; dst = stall_req;
      cyc();
      flush = 1'b0; req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (hilo_we === 1'b1) nw++;
         cyc();
      end
      checks++;
      if (dwe !== 1'b0 || dst !== 1'b0 || nw !== 0) begin
         failures++; $display("FAIL flush_done got we=%b stall=%b later_writes=%0d expected 0 0 0", dwe, dst, nw);
      end
   endtask

   task automatic test_reset_mid();
      int nv, vo, nw, wo; logic [31:0] hi, lo; logic sok, saw, sgn;
      stub_lat = 20;
      cyc();
      req_valid = 1'b1; req_sign = 1'b1; req_a = 32'd40; req_b = 32'd6;
      for (int k = 1; k <= 4; k++) cyc();
      rst = 1'b1; req_valid = 1'b0;
      cyc();
      checks++;
      if ({stall_req, hilo_we, div_valid, div_sign, div_err} !== 5'b0 || {div_a, div_b} !== 64'd0) begin
         failures++; $display("FAIL midrst_ctrl got ctrl=%b a=%h b=%h expected all zero", {stall_req, hilo_we, div_valid, div_sign, div_err}, div_a, div_b);
      end
      checks++;
      if ({hi_wdata, lo_wdata} !== 64'd0) begin
         failures++; $display("FAIL midrst_hilo got=%h expected=0", {hi_wdata, lo_wdata});
      end
      rst = 1'b0;
      stub_lat = 3;
      do_op(1'b0, 32'd9, 32'd3, nv, vo, nw, wo, hi, lo, sok, saw, sgn);
      checks++;
      if (lo !== 32'd3 || hi !== 32'd0 || nw !== 1 || wo !== 7) begin
         failures++; $display("FAIL midrst_fresh got lo=%h hi=%h writes=%0d at=%0d expected 3 0 1 7", lo, hi, nw, wo);
      end
   endtask

   task automatic test_back_to_back();
      int nv, vo, nw, wo; logic [31:0] hi, lo; logic sok, saw, sgn;
      stub_lat = 3;
      do_op(1'b0, 32'd20, 32'd3, nv, vo, nw, wo, hi, lo, sok, saw, sgn);
      checks++;
      if (lo !== 32'd6 || hi !== 32'd2 || nw !== 1) begin
         failures++; $display("FAIL b2b_first got lo=%h hi=%h writes=%0d expected 6 2 1", lo, hi, nw);
      end
      do_op(1'b0, 32'd45, 32'd7, nv, vo, nw, wo, hi, lo, sok, saw, sgn);
      checks++;
      if (lo !== 32'd6 || hi !== 32'd3 || nw !== 1 || nv !== 1) begin
         failures++; $display("FAIL b2b_second got lo=%h hi=%h writes=%0d launches=%0d expected 6 3 1 1", lo, hi, nw, nv);
      end
   endtask

`ifdef DIV_WATCHDOG_EN
   task automatic test_watchdog();
      int nw; logic e_before, e_after, st_after, e_held;
      nw = 0; e_held = 1'b1;
      stub_stuck = 1'b1;
      cyc();
      req_valid = 1'b1; req_sign = 1'b0; req_a = 32'd10; req_b = 32'd3;
      for (int k = 1; k <= 11; k++) begin
         cyc();
         if (hilo_we === 1'b1) nw++;
      end
      e_before = div_err;
      cyc();
      req_valid = 1'b0;
      #1;
      e_after = div_err; st_after = stall_req;
      for (int k = 0; k < 5; k++) begin
         if (hilo_we === 1'b1) nw++;
         if (div_err !== 1'b1) e_held = 1'b0;
         cyc();
      end
      checks++;
      if (e_before !== 1'b0 || e_after !== 1'b1 || st_after !== 1'b0) begin
         failures++; $display("FAIL watchdog_fire got before=%b after=%b stall=%b expected 0 1 0", e_before, e_after, st_after);
      end
      checks++;
      if (nw !== 0 || e_held !== 1'b1) begin
         failures++; $display("FAIL watchdog_sticky got writes=%0d held=%b expected 0 1", nw, e_held);
      end
      rst = 1'b1;
      cyc();
      checks++;
      if (div_err !== 1'b0) begin
         failures++; $display("FAIL watchdog_clear got=%b expected=0", div_err);
      end
      rst = 1'b0; stub_stuck = 1'b0;
      cyc();
   endtask
`endif

   initial begin
      test_reset();
      test_divu();
      test_div_signed();
      test_div_zero();
      test_flush_drain();
      test_flush_same_cycle();
      test_flush_at_done();
      test_reset_mid();
      test_back_to_back();
`ifdef DIV_WATCHDOG_EN
      test_watchdog();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
